// File: rtl/adder_rs_array.sv
// adder_rs_array: reservation-station array in front of one add/logic pipe.
// Ports: clock/reset; issue side (issue, opcode, A/B, *_invalid -> issued,
// available, RS_available, error); RS_executing; CDB master side (CDB_rts,
// CDB_xmit, CDB_*_out); CDB snoop side (CDB_*_in).
module adder_rs_array #(
  parameter int WIDTH    = 32,
  parameter int TAG_W    = 6,
  parameter int NUM_RS   = 3,
  parameter int BASE_TAG = 1,
  parameter int LATENCY  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             A_invalid,
  input  logic             B_invalid,
  output logic [TAG_W-1:0] issued,
  output logic             available,
  output logic [TAG_W-1:0] RS_available,
  output logic             error,
  output logic [TAG_W-1:0] RS_executing,
  output logic             CDB_rts,
  input  logic             CDB_xmit,
  output logic [WIDTH-1:0] CDB_data_out,
  output logic [TAG_W-1:0] CDB_source_out,
  output logic             CDB_write_out,
  input  logic [WIDTH-1:0] CDB_data_in,
  input  logic [TAG_W-1:0] CDB_source_in,
  input  logic             CDB_write_in
);

  localparam int IW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT
  } state_t;

  function automatic logic [TAG_W-1:0] f_tag(input int i);
    return TAG_W'(BASE_TAG + i);
  endfunction

  function automatic logic [IW-1:0] f_wrap(input int v);
    return (v >= NUM_RS) ? IW'(v - NUM_RS) : IW'(v);
  endfunction

  state_t             r_state;
  state_t             w_state_nx;
  logic [NUM_RS-1:0]  r_busy;
  logic [2:0]         r_op [NUM_RS];
  logic [WIDTH-1:0]   r_vj [NUM_RS];
  logic [WIDTH-1:0]   r_vk [NUM_RS];
  logic [TAG_W-1:0]   r_qj [NUM_RS];
  logic [TAG_W-1:0]   r_qk [NUM_RS];
  logic [IW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic [IW-1:0]      r_exec_idx;
  logic [WIDTH-1:0]   r_result;
  logic [TAG_W-1:0]   r_issued;
  logic               r_error;

  logic               w_free_found;
  logic [IW-1:0]      w_free_idx;
  logic [NUM_RS-1:0]  w_ready;
  logic               w_disp_found;
  logic [IW-1:0]      w_disp_idx;
  logic               w_dispatch;
  logic               w_grant;
  logic               w_bad_op;
  logic               w_issue_ok;
  logic               w_issue_err;
  logic [WIDTH-1:0]   w_vj;
  logic [WIDTH-1:0]   w_vk;
  logic [WIDTH-1:0]   w_alu;
  logic               w_a_hit;
  logic               w_b_hit;
  logic [WIDTH-1:0]   w_a_v;
  logic [WIDTH-1:0]   w_b_v;
  logic [TAG_W-1:0]   w_a_q;
  logic [TAG_W-1:0]   w_b_q;

  // lowest-index free station
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      w_ready[i] = r_busy[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
    end
  end

  // first ready station at or after the round-robin pointer
  always_comb begin
    w_disp_found = 1'b0;
    w_disp_idx   = '0;
    for (int k = NUM_RS - 1; k >= 0; k--) begin
      if (w_ready[f_wrap(int'(r_ptr) + k)]) begin
        w_disp_found = 1'b1;
        w_disp_idx   = f_wrap(int'(r_ptr) + k);
      end
    end
  end

  always_comb begin
    w_alu = '0;
    w_vj  = r_vj[w_disp_idx];
    w_vk  = r_vk[w_disp_idx];
    case (r_op[w_disp_idx])
      3'b000:  w_alu = w_vj + w_vk;
      3'b001:  w_alu = w_vj - w_vk;
      3'b100:  w_alu = w_vj | w_vk;
      3'b101:  w_alu = w_vj & w_vk;
      3'b110:  w_alu = ~w_vj;
      3'b111:  w_alu = w_vj ^ w_vk;
      default: w_alu = '0;
    endcase
  end

  assign w_bad_op    = (opcode[2:1] == 2'b01);
  assign w_issue_ok  = issue && !w_bad_op && w_free_found;
  assign w_issue_err = issue && (w_bad_op || !w_free_found);

  // an operand whose producer broadcasts this very cycle is taken off the bus
  assign w_a_hit = A_invalid && CDB_write_in
                && (CDB_source_in == A[TAG_W-1:0]);
  assign w_b_hit = B_invalid && CDB_write_in
                && (CDB_source_in == B[TAG_W-1:0]);
  assign w_a_v = w_a_hit ? CDB_data_in : A;
  assign w_b_v = w_b_hit ? CDB_data_in : B;
  assign w_a_q = (A_invalid && !w_a_hit) ? A[TAG_W-1:0] : '0;
  assign w_b_q = (B_invalid && !w_b_hit) ? B[TAG_W-1:0] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_dispatch = 1'b0;
    w_grant    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_disp_found) begin
          w_dispatch = 1'b1;
          w_state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (CDB_xmit) begin
          w_grant    = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy     <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_exec_idx <= '0;
      r_result   <= '0;
      r_issued   <= '0;
      r_error    <= 1'b0;
      for (int i = 0; i < NUM_RS; i++) begin
        r_op[i] <= '0;
        r_vj[i] <= '0;
        r_vk[i] <= '0;
        r_qj[i] <= '0;
        r_qk[i] <= '0;
      end
    end else begin
      r_issued <= '0;
      r_error  <= w_issue_err;
      if (CDB_write_in) begin
        for (int i = 0; i < NUM_RS; i++) begin
          if (r_busy[i] && r_qj[i] != '0 && r_qj[i] == CDB_source_in) begin
            r_vj[i] <= CDB_data_in;
            r_qj[i] <= '0;
          end
          if (r_busy[i] && r_qk[i] != '0 && r_qk[i] == CDB_source_in) begin
            r_vk[i] <= CDB_data_in;
            r_qk[i] <= '0;
          end
        end
      end
      if (w_issue_ok) begin
        r_busy[w_free_idx] <= 1'b1;
        r_op[w_free_idx]   <= opcode;
        r_vj[w_free_idx]   <= w_a_v;
        r_vk[w_free_idx]   <= w_b_v;
        r_qj[w_free_idx]   <= w_a_q;
        r_qk[w_free_idx]   <= w_b_q;
        r_issued           <= f_tag(int'(w_free_idx));
      end
      if (w_grant) r_busy[r_exec_idx] <= 1'b0;
      if (w_dispatch) begin
        r_ptr      <= f_wrap(int'(w_disp_idx) + 1);
        r_exec_idx <= w_disp_idx;
        r_result   <= w_alu;
        r_cnt      <= CW'(LATENCY - 1);
      end else if (r_state == S_EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign issued         = r_issued;
  assign error          = r_error;
  assign available      = w_free_found;
  assign RS_available   = w_free_found ? f_tag(int'(w_free_idx)) : '0;
  assign RS_executing   = (r_state != S_IDLE) ? f_tag(int'(r_exec_idx)) : '0;
  assign CDB_rts        = (r_state == S_WAIT);
  assign CDB_write_out  = CDB_xmit && CDB_rts;
  assign CDB_data_out   = CDB_rts ? r_result : '0;
  assign CDB_source_out = CDB_rts ? f_tag(int'(r_exec_idx)) : '0;

endmodule

// File: tb/tb_adder_rs_array.sv
// Bench for adder_rs_array: directed scenarios plus randomized traffic,
// every output compared against a cycle-level behavioural model.
module tb_adder_rs_array;

  localparam int N  = 3;
  localparam int L  = 2;
  localparam int BT = 1;

  logic        clock;
  logic        reset;
  logic        issue;
  logic [2:0]  opcode;
  logic [31:0] A;
  logic [31:0] B;
  logic        A_invalid;
  logic        B_invalid;
  logic [5:0]  issued;
  logic        available;
  logic [5:0]  RS_available;
  logic        error;
  logic [5:0]  RS_executing;
  logic        CDB_rts;
  logic        CDB_xmit;
  logic [31:0] CDB_data_out;
  logic [5:0]  CDB_source_out;
  logic        CDB_write_out;
  logic [31:0] CDB_data_in;
  logic [5:0]  CDB_source_in;
  logic        CDB_write_in;

  adder_rs_array #(
    .WIDTH(32), .TAG_W(6), .NUM_RS(N), .BASE_TAG(BT), .LATENCY(L)
  ) dut (
    .clock(clock), .reset(reset), .issue(issue), .opcode(opcode),
    .A(A), .B(B), .A_invalid(A_invalid), .B_invalid(B_invalid),
    .issued(issued), .available(available), .RS_available(RS_available),
    .error(error), .RS_executing(RS_executing), .CDB_rts(CDB_rts),
    .CDB_xmit(CDB_xmit), .CDB_data_out(CDB_data_out),
    .CDB_source_out(CDB_source_out), .CDB_write_out(CDB_write_out),
    .CDB_data_in(CDB_data_in), .CDB_source_in(CDB_source_in),
    .CDB_write_in(CDB_write_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy [N];
  logic [2:0]  m_op   [N];
  logic [31:0] m_vj   [N];
  logic [31:0] m_vk   [N];
  int          m_qj   [N];
  int          m_qk   [N];
  int          m_ptr;
  bit          m_infl;
  int          m_eidx;
  longint      m_ready;
  longint      m_cyc = 0;
  logic [31:0] m_res;
  int          m_issued;
  bit          m_error;

  function automatic logic [31:0] alu(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd4: return a | b;
      3'd5: return a & b;
      3'd6: return ~a;
      3'd7: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    int free;
    int d;
    bit bad;
    bit rts;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 0;
        m_qj[i] = 0;
        m_qk[i] = 0;
      end
      m_ptr = 0;
      m_infl = 0;
      m_issued = 0;
      m_error = 0;
    end else begin
      free = -1;
      for (int i = 0; i < N; i++)
        if (free < 0 && !m_busy[i]) free = i;
      bad = (opcode == 3'b010) || (opcode == 3'b011);
      rts = m_infl && (m_cyc >= m_ready);
      d = -1;
      if (!m_infl)
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (d < 0 && m_busy[j] && m_qj[j] == 0 && m_qk[j] == 0) d = j;
        end
      m_cyc++;
      m_error = issue && (bad || free < 0);
      m_issued = (issue && !bad && free >= 0) ? BT + free : 0;
      if (CDB_write_in)
        for (int i = 0; i < N; i++) if (m_busy[i]) begin
          if (m_qj[i] != 0 && m_qj[i] == int'(CDB_source_in)) begin
            m_vj[i] = CDB_data_in;
            m_qj[i] = 0;
          end
          if (m_qk[i] != 0 && m_qk[i] == int'(CDB_source_in)) begin
            m_vk[i] = CDB_data_in;
            m_qk[i] = 0;
          end
        end
      if (rts && CDB_xmit) begin
        m_busy[m_eidx] = 0;
        m_infl = 0;
      end
      if (d >= 0) begin
        m_infl = 1;
        m_eidx = d;
        m_ready = m_cyc + L;
        m_res = alu(m_op[d], m_vj[d], m_vk[d]);
        m_ptr = (d + 1) % N;
      end
      if (m_issued != 0) begin
        m_busy[free] = 1;
        m_op[free] = opcode;
        m_vj[free] = A;
        m_vk[free] = B;
        m_qj[free] = A_invalid ? int'(A[5:0]) : 0;
        m_qk[free] = B_invalid ? int'(B[5:0]) : 0;
        if (A_invalid && CDB_write_in && A[5:0] == CDB_source_in) begin
          m_vj[free] = CDB_data_in;
          m_qj[free] = 0;
        end
        if (B_invalid && CDB_write_in && B[5:0] == CDB_source_in) begin
          m_vk[free] = CDB_data_in;
          m_qk[free] = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    bit rts_e;
    int fr;
    rts_e = m_infl && (m_cyc >= m_ready);
    fr = -1;
    for (int i = 0; i < N; i++) if (fr < 0 && !m_busy[i]) fr = i;
    chk("issued", 64'(issued), 64'(m_issued));
    chk("error", 64'(error), 64'(m_error));
    chk("available", 64'(available), 64'(fr >= 0));
    chk("RS_available", 64'(RS_available), 64'(fr >= 0 ? BT + fr : 0));
    chk("RS_executing", 64'(RS_executing), 64'(m_infl ? BT + m_eidx : 0));
    chk("CDB_rts", 64'(CDB_rts), 64'(rts_e));
    chk("CDB_data_out", 64'(CDB_data_out), 64'(rts_e ? m_res : 32'd0));
    chk("CDB_source_out", 64'(CDB_source_out),
        64'(rts_e ? BT + m_eidx : 0));
    chk("CDB_write_out", 64'(CDB_write_out), 64'(rts_e && CDB_xmit));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    issue = 0; opcode = 0; A = 0; B = 0; A_invalid = 0; B_invalid = 0;
    CDB_xmit = 0; CDB_write_in = 0; CDB_source_in = 0; CDB_data_in = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    #2;
    reset = 0;
  endtask

  task automatic put(input logic [2:0] op, input logic [31:0] a,
                     input logic ai, input logic [31:0] b, input logic bi);
    issue = 1; opcode = op; A = a; A_invalid = ai; B = b; B_invalid = bi;
    tick();
    issue = 0; A_invalid = 0; B_invalid = 0;
  endtask

  task automatic drain_one(input logic [5:0] tg, input logic [31:0] dv);
    int n;
    n = 0;
    while (CDB_rts !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("drain_rts", 64'(CDB_rts), 64'(1));
    chk("drain_src", 64'(CDB_source_out), 64'(tg));
    chk("drain_data", 64'(CDB_data_out), 64'(dv));
    chk("drain_exec", 64'(RS_executing), 64'(tg));
    CDB_xmit = 1;
    #1;
    chk("drain_wr", 64'(CDB_write_out), 64'(1));
    tick();
    CDB_xmit = 0;
    chk("drain_drop", 64'(CDB_rts), 64'(0));
  endtask

  function automatic int pick_tag(input bit allow0);
    case ($urandom_range(0, allow0 ? 6 : 5))
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 9;
      4: return 10;
      5: return 11;
      default: return 0;
    endcase
  endfunction

  initial begin
    int n;
    set_idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    tick();

    // reset values
    chk("rst_issued", 64'(issued), 64'(0));
    chk("rst_avail", 64'(available), 64'(1));
    chk("rst_rsav", 64'(RS_available), 64'(BT));
    chk("rst_rts", 64'(CDB_rts), 64'(0));
    chk("rst_exec", 64'(RS_executing), 64'(0));

    // simple add, exact latency
    put(3'b000, 32'd5, 0, 32'd7, 0);
    chk("add_issued", 64'(issued), 64'(1));
    tick();
    chk("add_issued_clr", 64'(issued), 64'(0));
    chk("add_exec", 64'(RS_executing), 64'(1));
    tick();
    chk("add_rts_early", 64'(CDB_rts), 64'(0));
    tick();
    chk("add_rts", 64'(CDB_rts), 64'(1));
    chk("add_data", 64'(CDB_data_out), 64'(12));
    chk("add_src", 64'(CDB_source_out), 64'(1));
    CDB_xmit = 1;
    #1;
    chk("add_wr", 64'(CDB_write_out), 64'(1));
    tick();
    CDB_xmit = 0;
    chk("add_rts_drop", 64'(CDB_rts), 64'(0));
    chk("add_freed", 64'(RS_available), 64'(1));

    // fill, overflow, wake-up and round-robin drain
    do_reset();
    put(3'b000, 32'd10, 0, 32'd9, 1);
    put(3'b000, 32'd20, 0, 32'd9, 1);
    put(3'b000, 32'd30, 0, 32'd9, 1);
    chk("full_avail", 64'(available), 64'(0));
    chk("full_rsav", 64'(RS_available), 64'(0));
    put(3'b000, 32'd1, 0, 32'd1, 0);
    chk("full_err", 64'(error), 64'(1));
    chk("full_issued", 64'(issued), 64'(0));
    CDB_write_in = 1; CDB_source_in = 6'd9; CDB_data_in = 32'd3;
    tick();
    CDB_write_in = 0;
    chk("full_err_clr", 64'(error), 64'(0));
    drain_one(6'd1, 32'd13);
    drain_one(6'd2, 32'd23);
    drain_one(6'd3, 32'd33);

    // forwarding at issue
    do_reset();
    CDB_write_in = 1; CDB_source_in = 6'd9; CDB_data_in = 32'hFFFF_FFFF;
    put(3'b001, 32'd9, 1, 32'd1, 0);
    CDB_write_in = 0;
    drain_one(6'd1, 32'hFFFF_FFFE);

    // grant withheld
    do_reset();
    put(3'b000, 32'd1, 0, 32'd2, 0);
    put(3'b000, 32'd4, 0, 32'd5, 0);
    n = 0;
    while (CDB_rts !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_rts", 64'(CDB_rts), 64'(1));
      chk("hold_exec", 64'(RS_executing), 64'(1));
      tick();
    end
    drain_one(6'd1, 32'd3);
    drain_one(6'd2, 32'd9);

    // bad opcode, then not
    do_reset();
    put(3'b011, 32'd1, 0, 32'd1, 0);
    chk("bad_err", 64'(error), 64'(1));
    chk("bad_issued", 64'(issued), 64'(0));
    chk("bad_rsav", 64'(RS_available), 64'(1));
    put(3'b110, 32'd0, 0, 32'h1234, 0);
    chk("not_issued", 64'(issued), 64'(1));
    drain_one(6'd1, 32'hFFFF_FFFF);

    // reset in the middle of execute
    do_reset();
    put(3'b000, 32'd5, 0, 32'd7, 0);
    tick();
    tick();
    reset = 1;
    #1;
    chk("mid_rts", 64'(CDB_rts), 64'(0));
    chk("mid_exec", 64'(RS_executing), 64'(0));
    chk("mid_rsav", 64'(RS_available), 64'(1));
    chk("mid_data", 64'(CDB_data_out), 64'(0));
    #1;
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      CDB_xmit = 1;
      tick();
      chk("mid_never", 64'(CDB_rts), 64'(0));
    end
    CDB_xmit = 0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      issue = ($urandom_range(0, 1) == 1);
      opcode = 3'($urandom_range(0, 7));
      A = $urandom;
      B = $urandom;
      A_invalid = ($urandom_range(0, 3) == 0);
      B_invalid = ($urandom_range(0, 3) == 0);
      if (A_invalid) A = 32'(pick_tag(0));
      if (B_invalid) B = 32'(pick_tag(0));
      CDB_write_in = ($urandom_range(0, 2) == 0);
      CDB_source_in = 6'(pick_tag(1));
      CDB_data_in = $urandom;
      CDB_xmit = ($urandom_range(0, 1) == 1);
      tick();
    end
    set_idle();
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_rs_array.md
Name: adder_rs_array

Overview:
Parametrised integer add/logic functional unit for the Tomasulo core. It has NUM_RS reservation stations, a single execution pipeline of configurable latency, and a request/grant CDB interface. It generalises the fixed 3-station adder with:
- configurable width, depth and latency
- round-robin dispatch among ready stations
- same-cycle CDB forwarding at issue
- an invalid-opcode error
It sits between the issue stage and the CDB arbiter.

Parameters:
WIDTH  32  operand/result width
TAG_W  6  RS tag width; tag 0 means "operand valid"
NUM_RS  3  number of reservation stations (1..8)
BASE_TAG  1  tag of station 0; station i has tag BASE_TAG+i
LATENCY  2  execute cycles from dispatch to result ready (>=1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
issue  in  1  issue request this cycle
opcode  in  3  000 add, 001 sub, 100 or, 101 and, 110 not, 111 xor
A, B  in  WIDTH  operand value, or producer tag in [TAG_W-1:0] when invalid
A_invalid, B_invalid  in  1  operand is a pending tag
issued  out  TAG_W  tag of the accepted station, 0 if none
available  out  1  at least one station free
RS_available  out  TAG_W  tag the next issue will take, 0 if full
error  out  1  one-cycle pulse: issue rejected (full or bad opcode)
RS_executing  out  TAG_W  tag of the station in the pipeline, 0 if idle
CDB_rts  out  1  result waiting for the bus
CDB_xmit  in  1  grant from the CDB arbiter
CDB_data_out  out  WIDTH  result value
CDB_source_out  out  TAG_W  result tag
CDB_write_out  out  1  valid, driven only while CDB_xmit is high
CDB_data_in  in  WIDTH  snooped CDB data
CDB_source_in  in  TAG_W  snooped CDB tag
CDB_write_in  in  1  snooped CDB valid

Behaviour:
- Reset (async, any time, including mid-execute or mid-broadcast):
  - All stations free and the pipeline empty.
  - issued=0, error=0, CDB_rts=0, CDB_write_out=0, CDB_data_out=0, CDB_source_out=0, RS_executing=0.
  - available=1, RS_available=BASE_TAG, round-robin pointer=0.
- Issue (clock edge with issue=1):
  - The request takes the lowest-index free station.
  - issued = its tag for exactly one cycle; otherwise issued=0.
  - Operand with invalid=0: V<=value, Q<=0. Operand with invalid=1: Q<=A/B[TAG_W-1:0].
  - Forwarding: if CDB_write_in=1 and CDB_source_in equals that tag in the same cycle, capture CDB_data_in with Q<=0.
  - If all stations are busy: error=1 for one cycle and no state change.
  - Opcode 010 or 011: error=1 for one cycle and nothing is allocated.
- Snoop (every edge with CDB_write_in=1): every busy station with Qj or Qk equal to CDB_source_in captures CDB_data_in and clears that Q. This includes the unit's own broadcasts.
- Dispatch:
  - Condition: pipeline idle and no result held.
  - Selection: among busy stations with Qj=Qk=0, round-robin starting at the pointer.
  - The pointer moves to the dispatched index+1, mod NUM_RS.
  - A station made ready by snoop in cycle N may dispatch at N+1, not earlier.
- Execute FSM:
  - States: IDLE -> EXEC (LATENCY cycles) -> WAIT.
  - In WAIT: CDB_rts=1, CDB_data_out and CDB_source_out hold the result and tag.
  - RS_executing = the tag from dispatch until broadcast completes.
- Arithmetic:
  - Modulo 2^WIDTH; no overflow flag.
  - not = ~Vj; Vk is ignored.
  - sub = Vj - Vk in two's complement.
- Broadcast:
  - On an edge with CDB_xmit=1 in WAIT: the station is freed and the FSM goes to IDLE.
  - CDB_rts drops the next cycle.
  - CDB_write_out = CDB_xmit & (state==WAIT).
  - CDB_xmit in any other state is ignored.
  - The freed station is issuable from the following cycle.
  - A new dispatch may occur on the edge after the grant.
- available and RS_available are combinational from the busy bits.

Test Plan:
- Reset, then issue add A=5, B=7 (valid) -> issued=BASE_TAG next cycle; CDB_rts=1 after LATENCY+1 edges; on grant, CDB_data_out=12 and CDB_source_out=1; station freed.
- Issue NUM_RS ops with B_invalid (tag 9), then a 4th issue -> error pulse, available=0, RS_available=0. Then drive CDB_write_in=1, source 9, data 3 -> all stations ready; dispatch order is round-robin 1,2,3.
- Issue with A_invalid tag 9 while CDB broadcasts tag 9 data 0xFFFF_FFFF in the same cycle -> operand captured. sub with B=1 gives 0xFFFF_FFFE.
- Hold CDB_xmit=0 for 10 cycles with a result in WAIT -> CDB_rts stays 1, no second dispatch, RS_executing stable. Then grant -> rts low the next cycle.
- Issue opcode 011 -> error=1, issued=0, no station allocated. Issue not A=0 -> result 0xFFFF_FFFF.
- Assert reset during EXEC -> all outputs return to their reset values immediately; the held result is never broadcast.
